// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//
// Round-robin arbiter that shares one serial transmitter between N_REQ byte
// producers. In IDLE it picks the next requester (search starts at ptr and wraps),
// latches its byte and pulses send. It then follows the transmitter's
// transmission flag through frame start and frame end. A forced idle gap
// follows each frame before the next grant.
//
// Ports:
//   clk          clock, shared with the transmitter
//   rst_n        asynchronous active-low reset
//   req          level request per requester
//   req_data     packed bytes, requester i at [i*DATA_W +: DATA_W]
//   ack          one-hot pulse: byte of requester i latched
//   tx_send      one-cycle pulse to the transmitter's send input
//   tx_data      byte to the transmitter, held from grant to next grant
//   tx_busy      transmitter's transmission output
//   grant_id     index of the current or most recent grant
//   busy         high in every state except IDLE (combinational from state)
//   timeout_err  one-cycle pulse when tx_busy fails to rise in time

module serial_tx_arbiter #(
    parameter int unsigned ID_W          = 2,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned START_TIMEOUT = 255,
    parameter int unsigned GAP_CYCLES    = 4,
    localparam int unsigned N_REQ        = 1 << ID_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    tx_send,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    // Shared by the start-timeout and gap counts; both limits fit in 16 bits.
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWaitStart,
        StWaitDone,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               tx_send_q, tx_send_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               timeout_err_q, timeout_err_d;

    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    idx;
    logic               found;

    // Round-robin pick: first set request at or after ptr, wrapping in ID_W bits.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr_q + ID_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        ack_d         = '0;
        tx_send_d     = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A frame still shifting (e.g. after a mid-frame reset) blocks grants.
                if (found && !tx_busy) begin
                    tx_data_d   = req_data[sel*DATA_W +: DATA_W];
                    grant_id_d  = sel;
                    ack_d[sel]  = 1'b1;
                    tx_send_d   = 1'b1;
                    ptr_d       = sel + ID_W'(1);
                    cnt_d       = '0;
                    state_d     = StWaitStart;
                end
            end
            StWaitStart: begin
                // cnt_q counts cycles since tx_send; deciding one cycle early lets
                // the registered error land exactly START_TIMEOUT cycles after send.
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = StGap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                // GAP_CYCLES == 0 still spends one cycle here.
                if (32'(cnt_q) + 32'd1 >= GAP_CYCLES) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ptr_q         <= '0;
            ack_q         <= '0;
            tx_send_q     <= 1'b0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            ack_q         <= ack_d;
            tx_send_q     <= tx_send_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ack         = ack_q;
    assign tx_send     = tx_send_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (START_TIMEOUT=8, GAP_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge. A small
// transmitter model raises tx_busy 2 cycles after send and holds it 10 cycles.

module tb_serial_tx_arbiter;

    localparam int unsigned ID_W   = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_REQ  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_REQ-1:0]  req;
    logic [31:0]       req_data;
    logic [N_REQ-1:0]  ack;
    logic              tx_send;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic [ID_W-1:0]   grant_id;
    logic              busy;
    logic              timeout_err;

    logic        model_en;
    logic        model_busy;
    logic        force_busy;
    int unsigned m_cnt;
    int unsigned cyc;
    int unsigned last;
    int          n_run;
    int          n_fail;
    logic        ok;

    assign tx_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    serial_tx_arbiter #(
        .ID_W         (ID_W),
        .DATA_W       (DATA_W),
        .START_TIMEOUT(8),
        .GAP_CYCLES   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_send    (tx_send),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and update the transmitter model.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (model_en) begin
            if (tx_send === 1'b1) m_cnt = 1;
            else if (m_cnt != 0) m_cnt = (m_cnt == 12) ? 0 : m_cnt + 1;
        end
        model_busy = (m_cnt >= 3);
    endtask

    task automatic wait_send(input string tag);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (tx_send === 1'b1) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (busy === 1'b0) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        n_run      = 0;
        n_fail     = 0;
        cyc        = 0;
        last       = 0;
        m_cnt      = 0;
        model_busy = 1'b0;
        model_en   = 1'b1;
        force_busy = 1'b0;
        req        = '0;
        req_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        rst_n      = 1'b0;

        // Reset and quiet idle.
        step();
        step();
        chk("reset_outputs", 32'({ack, tx_send, tx_data, grant_id, busy, timeout_err}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_quiet", 32'({ack, tx_send, tx_data, grant_id, busy, timeout_err}), 32'd0);
        end

        // Round-robin with all requesters active: 0,1,2,3,0, 18 cycles apart.
        req = 4'b1111;
        step();
        chk("rr_latency_send", 32'(tx_send), 32'd1);
        chk("rr_grant0", 32'(grant_id), 32'd0);
        chk("rr_ack0", 32'(ack), 32'h1);
        chk("rr_data0", 32'(tx_data), 32'h11);
        last = cyc;
        for (int f = 1; f <= 4; f++) begin
            wait_send("rr_send");
            chk("rr_grant", 32'(grant_id), 32'(f % 4));
            chk("rr_ack", 32'(ack), 32'(1 << (f % 4)));
            chk("rr_spacing", cyc - last, 32'd18);
            last = cyc;
        end
        req = '0;
        wait_idle("rr_idle");

        // Single requester 2, byte A5.
        req = 4'b0100;
        step();
        chk("single_send", 32'(tx_send), 32'd1);
        chk("single_ack", 32'(ack), 32'h4);
        chk("single_grant", 32'(grant_id), 32'd2);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_busy", 32'(busy), 32'd1);
        req = '0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("single_data_stable", 32'(tx_data), 32'hA5);
            chk("single_no_send", 32'({ack, tx_send}), 32'd0);
        end
        chk("single_gap_busy", 32'(busy), 32'd1);
        step();
        chk("single_back_idle", 32'(busy), 32'd0);

        // Transmitter busy while idle: grant waits for it to fall.
        force_busy = 1'b1;
        req        = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("busyidle_hold", 32'({tx_send, busy}), 32'd0);
        end
        force_busy = 1'b0;
        step();
        chk("busyidle_send", 32'(tx_send), 32'd1);
        chk("busyidle_ack", 32'(ack), 32'h1);
        chk("busyidle_grant", 32'(grant_id), 32'd0);
        req = '0;
        wait_idle("busyidle_idle");

        // Start timeout: model silent, error 8 cycles after send, pending req served.
        model_en   = 1'b0;
        m_cnt      = 0;
        req        = 4'b1000;
        step();
        chk("to_send", 32'(tx_send), 32'd1);
        chk("to_grant", 32'(grant_id), 32'd3);
        req = 4'b0010;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("to_early", 32'(timeout_err), 32'd0);
        end
        step();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_gap_busy", 32'(busy), 32'd1);
        step();
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        step();
        step();
        chk("to_gap_last", 32'(busy), 32'd1);
        step();
        chk("to_idle", 32'(busy), 32'd0);
        model_en = 1'b1;
        step();
        chk("to_next_send", 32'(tx_send), 32'd1);
        chk("to_next_grant", 32'(grant_id), 32'd1);
        chk("to_next_ack", 32'(ack), 32'h2);
        req = '0;
        wait_idle("to_idle_after");

        // Reset during WAIT_DONE.
        req = 4'b0100;
        step();
        chk("rst_send", 32'(tx_send), 32'd1);
        chk("rst_grant", 32'(grant_id), 32'd2);
        req = '0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({ack, tx_send, tx_data, grant_id, busy, timeout_err}), 32'd0);
        step();
        req   = 4'b1111;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_wait_txbusy", 32'(tx_send), 32'd0);
        end
        step();
        chk("rst_regrant_send", 32'(tx_send), 32'd1);
        chk("rst_ptr_zero", 32'(grant_id), 32'd0);
        chk("rst_regrant_ack", 32'(ack), 32'h1);
        req = '0;
        wait_idle("rst_idle");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
